// File: rtl/clk_sel_ctrl.sv
// Source-select controller for the glitch-free two-input clock mux; qualifies in1_clk before switching to it.
// Build option: define CLK_SEL_AUTO_REVERT_EN to fall back to in0_clk automatically when in1_clk is lost in ON1.
module clk_sel_ctrl #(
    parameter int TIMEOUT_CYC  = 64,
    parameter int QUAL_TOGGLES = 8,
    parameter int SETTLE_CYC   = 8
) (
    input  logic in0_clk,
    input  logic in0_arst,
    input  logic in1_clk,
    input  logic in1_arst,
    input  logic req_sel,
    input  logic clr_fault,
    output logic sel,
    output logic cur_src,
    output logic busy,
    output logic done,
    output logic in1_alive,
    output logic fault
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int QW = $clog2(QUAL_TOGGLES + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_CYC);
    localparam logic [QW-1:0] QUAL_MAX    = QW'(QUAL_TOGGLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE0 = 2'd0,
        SW_UP = 2'd1,
        ON1   = 2'd2,
        SW_DN = 2'd3
    } state_t;

    logic          tog1_r;
    logic          s1_r, s2_r, s3_r;
    logic [TW-1:0] to_cnt_r;
    logic [QW-1:0] qual_cnt_r;
    logic          in1_alive_r;
    logic          edge_s, lost_s, settle_done_s;

    state_t        state_r, state_nxt_s;
    logic [SW-1:0] settle_cnt_r, settle_nxt_s;
    logic          sel_r, cur_src_r, busy_r, done_r, fault_r;
    logic          sel_nxt_s, cur_src_nxt_s, busy_nxt_s, done_nxt_s, fault_nxt_s;

    // Toggle flop in the in1 domain: flips on every in1_clk rising edge.
    always_ff @(posedge in1_clk or posedge in1_arst) begin
        if (in1_arst) begin
            tog1_r <= 1'b0;
        end else begin
            tog1_r <= ~tog1_r;
        end
    end

    // Two-flop synchronizer plus history flop for edge detection.
    always_ff @(posedge in0_clk or posedge in0_arst) begin
        if (in0_arst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= tog1_r;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign edge_s        = s2_r ^ s3_r;
    assign lost_s        = (to_cnt_r == TO_MAX);
    assign settle_done_s = (settle_cnt_r == SETTLE_LAST);

    // Liveness monitor: timeout counter, qualification counter and alive flag.
    always_ff @(posedge in0_clk or posedge in0_arst) begin
        if (in0_arst) begin
            to_cnt_r    <= '0;
            qual_cnt_r  <= '0;
            in1_alive_r <= 1'b0;
        end else begin
            if (edge_s) begin
                to_cnt_r <= '0;
            end else if (to_cnt_r != TO_MAX) begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end else begin
                to_cnt_r <= to_cnt_r;
            end
            // Loss dominates so a dying clock cannot keep qualifying itself.
            if (lost_s) begin
                qual_cnt_r  <= '0;
                in1_alive_r <= 1'b0;
            end else begin
                if (edge_s && (qual_cnt_r != QUAL_MAX)) begin
                    qual_cnt_r <= qual_cnt_r + QW'(1);
                end else begin
                    qual_cnt_r <= qual_cnt_r;
                end
                in1_alive_r <= in1_alive_r | (qual_cnt_r == QUAL_MAX);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge in0_clk or posedge in0_arst) begin
        if (in0_arst) begin
            state_r <= IDLE0;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; req_sel is only looked at in the stable states.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE0: begin
                if (req_sel && in1_alive_r) state_nxt_s = SW_UP;
                else                        state_nxt_s = IDLE0;
            end
            SW_UP: begin
                if (lost_s)             state_nxt_s = SW_DN;
                else if (settle_done_s) state_nxt_s = ON1;
                else                    state_nxt_s = SW_UP;
            end
            ON1: begin
                if (!req_sel)     state_nxt_s = SW_DN;
`ifdef CLK_SEL_AUTO_REVERT_EN
                else if (lost_s)  state_nxt_s = SW_DN;
`endif
                else              state_nxt_s = ON1;
            end
            SW_DN: begin
                if (settle_done_s) state_nxt_s = IDLE0;
                else               state_nxt_s = SW_DN;
            end
            default: state_nxt_s = IDLE0;
        endcase
    end

    // FSM outputs, computed from the transition so they can be registered.
    always_comb begin
        sel_nxt_s     = (state_nxt_s == SW_UP) || (state_nxt_s == ON1);
        done_nxt_s    = 1'b0;
        cur_src_nxt_s = cur_src_r;
        if ((state_r == SW_UP) && (state_nxt_s == ON1)) begin
            done_nxt_s    = 1'b1;
            cur_src_nxt_s = 1'b1;
        end else if ((state_r == SW_DN) && (state_nxt_s == IDLE0)) begin
            done_nxt_s    = 1'b1;
            cur_src_nxt_s = 1'b0;
        end else begin
            done_nxt_s    = 1'b0;
            cur_src_nxt_s = cur_src_r;
        end
        busy_nxt_s = (req_sel != cur_src_nxt_s) || (state_nxt_s == SW_UP) || (state_nxt_s == SW_DN);
        if (state_nxt_s != state_r) begin
            settle_nxt_s = '0;
        end else if ((state_r == SW_UP) || (state_r == SW_DN)) begin
            settle_nxt_s = settle_cnt_r + SW'(1);
        end else begin
            settle_nxt_s = '0;
        end
        // A loss while selected sets the fault, beating a same-cycle clear.
        if (sel_r && lost_s) begin
            fault_nxt_s = 1'b1;
        end else if (clr_fault) begin
            fault_nxt_s = 1'b0;
        end else begin
            fault_nxt_s = fault_r;
        end
    end

    // Output and settle-counter registers.
    always_ff @(posedge in0_clk or posedge in0_arst) begin
        if (in0_arst) begin
            settle_cnt_r <= '0;
            sel_r        <= 1'b0;
            cur_src_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            settle_cnt_r <= settle_nxt_s;
            sel_r        <= sel_nxt_s;
            cur_src_r    <= cur_src_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            fault_r      <= fault_nxt_s;
        end
    end

    assign sel       = sel_r;
    assign cur_src   = cur_src_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign in1_alive = in1_alive_r;
    assign fault     = fault_r;

endmodule
